// File: rtl/uart_pkg.sv
// Shared UART types: parity modes, Rx FSM states, error bit positions
// and the baud divider helper shared by the Rx and Tx engines.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_EVEN,
        PAR_ODD
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BRK_WAIT
    } rx_state_e;

    localparam int ERR_BREAK  = 0;
    localparam int ERR_PARITY = 1;
    localparam int ERR_FRAME  = 2;

    function automatic int calc_div(
        input int sysclk,
        input int baud,
        input int os
    );
        int d;
        d = sysclk / (baud * os);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_rx_engine_if.sv
// Valid/ready bundle carrying {data, error} from the Rx engine
// into the Rx FIFO.
interface uart_rx_engine_if #(
    parameter int MAX_DATA_BITS = 9
);
    logic [MAX_DATA_BITS-1:0] Data_Out;
    logic [2:0]               Rx_Error;
    logic                     Data_Valid;
    logic                     Data_Ready;

    modport master (
        output Data_Out,
        output Rx_Error,
        output Data_Valid,
        input  Data_Ready
    );

    modport slave (
        input  Data_Out,
        input  Rx_Error,
        input  Data_Valid,
        output Data_Ready
    );
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks while
// enabled; clear restarts the phase so ticks align to an event.
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clear || !enable) cnt <= '0;
        else if (cnt == LAST)           cnt <= '0;
        else                            cnt <= cnt + 1'b1;
    end

    assign tick = enable && !clear && (cnt == LAST);
endmodule

// File: rtl/uart_rx_engine.sv
// UART receive engine: oversampled start detect, 3-sample vote, runtime
// frame format. Optional stats counters under UART_RX_STATS_EN.
module uart_rx_engine
    import uart_pkg::*;
#(
    parameter int SYSCLK_RATE   = 100000000,
    parameter int BAUD_RATE     = 9600,
    parameter int OVERSAMPLE    = 16,
    parameter int MAX_DATA_BITS = 9,
    parameter int MSB_FIRST     = 1
) (
    input  logic                 SysClk,
    input  logic                 Rst,
    input  logic                 Rx,
    input  logic [3:0]           Cfg_Data_Bits,
    input  logic [1:0]           Cfg_Parity,
    input  logic                 Cfg_Stop_Bits,
    uart_rx_engine_if.master     fifo,
    output logic                 Overrun,
    output logic                 Rx_Busy
`ifdef UART_RX_STATS_EN
    ,
    output logic [15:0]          Stat_Frames,
    output logic [15:0]          Stat_Errors
`endif
);
    localparam int DIV = calc_div(SYSCLK_RATE, BAUD_RATE, OVERSAMPLE);
    localparam int OSW = $clog2(OVERSAMPLE);
    localparam int IW  = $clog2(MAX_DATA_BITS);
    localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
    localparam logic [OSW-1:0] MID_LO  = OSW'(OVERSAMPLE / 2 - 1);
    localparam logic [OSW-1:0] MID     = OSW'(OVERSAMPLE / 2);
    localparam logic [OSW-1:0] MID_HI  = OSW'(OVERSAMPLE / 2 + 1);

    rx_state_e state, state_d;

    logic                     rx_meta, rx_s, rx_prev;
    logic [OSW-1:0]           os_cnt;
    logic                     s0, s1;
    logic [3:0]               bit_cnt;
    logic                     stop_cnt;
    logic [MAX_DATA_BITS-1:0] shreg;
    logic                     pbit, frame_err;
    logic [3:0]               cfg_bits, bits_in;
    parity_e                  cfg_par, par_in;
    logic                     cfg_stop;

    logic [MAX_DATA_BITS-1:0] data_q;
    logic [2:0]               err_q;
    logic                     valid_q, ovr_q;

    logic           tick, start_edge, vote_now, vote;
    logic           last_data, par_err, brk, complete, accept, ovr;
    logic [2:0]     new_err;
    logic [IW-1:0]  idx;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk    (SysClk),
        .rst_n  (Rst),
        .clear  (start_edge),
        .enable (state != ST_IDLE),
        .tick   (tick)
    );

    always_comb begin
        bits_in = 4'd8;
        if (Cfg_Data_Bits >= 4'd5 && Cfg_Data_Bits <= 4'd9 &&
            int'(Cfg_Data_Bits) <= MAX_DATA_BITS)
            bits_in = Cfg_Data_Bits;
        case (Cfg_Parity)
            2'b01:   par_in = PAR_EVEN;
            2'b10:   par_in = PAR_ODD;
            default: par_in = PAR_NONE;
        endcase
    end

    assign start_edge = (state == ST_IDLE) && rx_prev && !rx_s;
    assign vote_now   = tick && (os_cnt == MID_HI);
    assign vote       = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
    assign last_data  = (bit_cnt == cfg_bits - 4'd1);
    assign idx        = (MSB_FIRST != 0) ? IW'(cfg_bits - 4'd1 - bit_cnt)
                                         : IW'(bit_cnt);
    assign par_err    = (cfg_par != PAR_NONE) &&
                        ((^shreg ^ pbit) != (cfg_par == PAR_ODD));
    assign brk        = (shreg == '0) &&
                        (cfg_par == PAR_NONE || !pbit) && !vote;

    always_ff @(posedge SysClk) begin
        if (!Rst) state <= ST_IDLE;
        else      state <= state_d;
    end

    always_comb begin
        state_d  = state;
        complete = 1'b0;
        new_err  = '0;
        unique case (state)
            ST_IDLE:
                if (start_edge) state_d = ST_START;
            ST_START:
                if (vote_now) state_d = vote ? ST_IDLE : ST_DATA;
            ST_DATA:
                if (vote_now && last_data)
                    state_d = (cfg_par == PAR_NONE) ? ST_STOP : ST_PARITY;
            ST_PARITY:
                if (vote_now) state_d = ST_STOP;
            ST_STOP:
                if (vote_now) begin
                    if (!stop_cnt && brk) begin
                        state_d             = ST_BRK_WAIT;
                        complete            = 1'b1;
                        new_err[ERR_BREAK]  = 1'b1;
                    end else if (stop_cnt || !cfg_stop) begin
                        // Leave at mid-bit so the next start edge is seen
                        state_d             = ST_IDLE;
                        complete            = 1'b1;
                        new_err[ERR_FRAME]  = frame_err || !vote;
                        new_err[ERR_PARITY] = par_err;
                    end
                end
            ST_BRK_WAIT:
                if (rx_s) state_d = ST_IDLE;
            default:
                state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge SysClk) begin
        if (!Rst) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            rx_prev   <= 1'b1;
            os_cnt    <= '0;
            s0        <= 1'b1;
            s1        <= 1'b1;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            shreg     <= '0;
            pbit      <= 1'b0;
            frame_err <= 1'b0;
            cfg_bits  <= 4'd8;
            cfg_par   <= PAR_NONE;
            cfg_stop  <= 1'b0;
        end else begin
            rx_meta <= Rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
            if (start_edge) begin
                os_cnt    <= '0;
                bit_cnt   <= '0;
                stop_cnt  <= 1'b0;
                shreg     <= '0;
                pbit      <= 1'b0;
                frame_err <= 1'b0;
                cfg_bits  <= bits_in;
                cfg_par   <= par_in;
                cfg_stop  <= Cfg_Stop_Bits;
            end else if (tick) begin
                os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + 1'b1;
                if (os_cnt == MID_LO) s0 <= rx_s;
                if (os_cnt == MID)    s1 <= rx_s;
                if (os_cnt == MID_HI) begin
                    case (state)
                        ST_DATA: begin
                            shreg[idx] <= vote;
                            bit_cnt    <= bit_cnt + 4'd1;
                        end
                        ST_PARITY: pbit <= vote;
                        ST_STOP: begin
                            frame_err <= frame_err | ~vote;
                            stop_cnt  <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign accept = valid_q && fifo.Data_Ready;
    assign ovr    = complete && valid_q && !fifo.Data_Ready;

    always_ff @(posedge SysClk) begin
        if (!Rst) begin
            data_q  <= '0;
            err_q   <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ovr_q <= ovr;
            if (complete && !ovr) begin
                data_q  <= shreg;
                err_q   <= new_err;
                valid_q <= 1'b1;
            end else if (accept) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign fifo.Data_Out   = data_q;
    assign fifo.Rx_Error   = err_q;
    assign fifo.Data_Valid = valid_q;
    assign Overrun         = ovr_q;
    assign Rx_Busy         = (state != ST_IDLE);

`ifdef UART_RX_STATS_EN
    logic [15:0] frames_q, errors_q;

    always_ff @(posedge SysClk) begin
        if (!Rst) begin
            frames_q <= '0;
            errors_q <= '0;
        end else if (complete) begin
            if (frames_q != 16'hFFFF) frames_q <= frames_q + 16'd1;
            if ((new_err != 3'b000 || ovr) && errors_q != 16'hFFFF)
                errors_q <= errors_q + 16'd1;
        end
    end

    assign Stat_Frames = frames_q;
    assign Stat_Errors = errors_q;
`endif
endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed and randomized frames for uart_rx_engine, checked against a
// frame-level reference model (16 clocks per bit, DIV=1).
module tb_uart_rx_engine;
    localparam int BITT = 16;

    logic       SysClk = 1'b0;
    logic       Rst    = 1'b0;
    logic       Rx     = 1'b1;
    logic [3:0] cfg_bits = 4'd8;
    logic [1:0] cfg_par  = 2'b01;
    logic       cfg_stop = 1'b1;
    logic       Overrun, Rx_Busy;
`ifdef UART_RX_STATS_EN
    logic [15:0] stat_frames, stat_errors;
`endif

    int total   = 0;
    int bad     = 0;
    int ovr_cnt = 0;

    uart_rx_engine_if #(.MAX_DATA_BITS(9)) fifo ();

    uart_rx_engine #(
        .SYSCLK_RATE   (1600000),
        .BAUD_RATE     (100000),
        .OVERSAMPLE    (16),
        .MAX_DATA_BITS (9),
        .MSB_FIRST     (1)
    ) dut (
        .SysClk        (SysClk),
        .Rst           (Rst),
        .Rx            (Rx),
        .Cfg_Data_Bits (cfg_bits),
        .Cfg_Parity    (cfg_par),
        .Cfg_Stop_Bits (cfg_stop),
        .fifo          (fifo),
        .Overrun       (Overrun),
        .Rx_Busy       (Rx_Busy)
`ifdef UART_RX_STATS_EN
        ,
        .Stat_Frames   (stat_frames),
        .Stat_Errors   (stat_errors)
`endif
    );

    always #5 SysClk = ~SysClk;

    always @(negedge SysClk) if (Overrun === 1'b1) ovr_cnt++;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] mask(input int nb);
        logic [9:0] m;
        m = (10'd1 << nb) - 10'd1;
        return m[8:0];
    endfunction

    // Reference: error word from the frame as it was put on the line
    function automatic logic [2:0] model_err(input logic [8:0] d,
        input logic [1:0] par, input logic flip, input int ns,
        input logic [1:0] stops);
        logic pen, pb, st2;
        pen = (par == 2'b01) || (par == 2'b10);
        pb  = (^d) ^ (par == 2'b10) ^ flip;
        st2 = (ns == 2) ? stops[1] : 1'b1;
        if (d == 9'd0 && (!pen || !pb) && !stops[0]) return 3'b001;
        return {!stops[0] || !st2, pen && flip, 1'b0};
    endfunction

    task automatic send_bit(input logic b);
        Rx = b;
        repeat (BITT) @(negedge SysClk);
    endtask

    task automatic send_head(input logic [8:0] d, input int nb,
                             input logic [1:0] par, input logic flip);
        send_bit(1'b0);
        for (int i = nb - 1; i >= 0; i--) send_bit(d[i]);
        if (par == 2'b01 || par == 2'b10)
            send_bit((^d) ^ (par == 2'b10) ^ flip);
    endtask

    task automatic send_frame(input logic [8:0] d, input int nb,
        input logic [1:0] par, input int ns, input logic flip,
        input logic [1:0] stops);
        send_head(d, nb, par, flip);
        send_bit(stops[0]);
        if (ns == 2) send_bit(stops[1]);
        send_bit(1'b1);
        send_bit(1'b1);
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (fifo.Data_Valid !== 1'b1 && n < 3 * BITT) begin
            @(negedge SysClk);
            n++;
        end
        check(tag, 32'(fifo.Data_Valid), 32'd1);
    endtask

    task automatic accept();
        fifo.Data_Ready = 1'b1;
        @(negedge SysClk);
        fifo.Data_Ready = 1'b0;
    endtask

    initial begin
        logic [8:0] d;
        logic [1:0] parm, stops;
        logic       flip;
        int         nb, ns, ovr0;

        fifo.Data_Ready = 1'b0;
        repeat (4) @(negedge SysClk);
        check("rst_data",  32'(fifo.Data_Out),   32'd0);
        check("rst_err",   32'(fifo.Rx_Error),   32'd0);
        check("rst_valid", 32'(fifo.Data_Valid), 32'd0);
        check("rst_ovr",   32'(Overrun),         32'd0);
        check("rst_busy",  32'(Rx_Busy),         32'd0);
        Rst = 1'b1;
        repeat (2 * BITT) @(negedge SysClk);

        // 0xA5, even parity, 2 stops: latency, hold, drop
        send_head(9'h0A5, 8, 2'b01, 1'b0);
        send_bit(1'b1);
        repeat (11) @(negedge SysClk);
        check("a5_early", 32'(fifo.Data_Valid), 32'd0);
        repeat (3) @(negedge SysClk);
        check("a5_on", 32'(fifo.Data_Valid), 32'd1);
        repeat (2) @(negedge SysClk);
        send_bit(1'b1);
        send_bit(1'b1);
        check("a5_data", 32'(fifo.Data_Out), 32'h0A5);
        check("a5_err",  32'(fifo.Rx_Error), 32'd0);
        repeat (20) @(negedge SysClk);
        check("a5_hold_v", 32'(fifo.Data_Valid), 32'd1);
        check("a5_hold_d", 32'(fifo.Data_Out),   32'h0A5);
        accept();
        check("a5_drop", 32'(fifo.Data_Valid), 32'd0);

        send_frame(9'h0AA, 8, 2'b01, 2, 1'b1, 2'b11);
        wait_valid("aa_valid");
        check("aa_data", 32'(fifo.Data_Out), 32'h0AA);
        check("aa_err",  32'(fifo.Rx_Error), 32'b010);
        accept();

        send_frame(9'h03C, 8, 2'b01, 2, 1'b0, 2'b00);
        wait_valid("3c_valid");
        check("3c_err", 32'(fifo.Rx_Error), 32'b100);
        accept();
        send_frame(9'h055, 8, 2'b01, 2, 1'b0, 2'b11);
        wait_valid("55_valid");
        check("55_data", 32'(fifo.Data_Out), 32'h055);
        check("55_err",  32'(fifo.Rx_Error), 32'd0);
        accept();

        ovr0 = ovr_cnt;
        Rx = 1'b0;
        repeat (20 * BITT) @(negedge SysClk);
        check("brk_busy",  32'(Rx_Busy),         32'd1);
        check("brk_valid", 32'(fifo.Data_Valid), 32'd1);
        check("brk_data",  32'(fifo.Data_Out),   32'd0);
        check("brk_err",   32'(fifo.Rx_Error),   32'b001);
        Rx = 1'b1;
        repeat (4) @(negedge SysClk);
        check("brk_idle", 32'(Rx_Busy), 32'd0);
        accept();
        repeat (3 * BITT) @(negedge SysClk);
        check("brk_one",  32'(fifo.Data_Valid), 32'd0);
        check("brk_novr", 32'(ovr_cnt - ovr0),  32'd0);

        ovr0 = ovr_cnt;
        send_frame(9'h011, 8, 2'b01, 2, 1'b0, 2'b11);
        send_frame(9'h022, 8, 2'b01, 2, 1'b0, 2'b11);
        wait_valid("ovr_valid");
        check("ovr_data",  32'(fifo.Data_Out), 32'h011);
        check("ovr_pulse", 32'(ovr_cnt - ovr0), 32'd1);
        accept();
        repeat (3 * BITT) @(negedge SysClk);
        check("ovr_gone", 32'(fifo.Data_Valid), 32'd0);

        Rx = 1'b0;
        repeat (4) @(negedge SysClk);
        Rx = 1'b1;
        repeat (3 * BITT) @(negedge SysClk);
        check("gl_valid", 32'(fifo.Data_Valid), 32'd0);
        check("gl_busy",  32'(Rx_Busy),         32'd0);

        cfg_bits = 4'd7; cfg_par = 2'b10; cfg_stop = 1'b0;
        send_frame(9'h05A, 7, 2'b10, 1, 1'b0, 2'b11);
        wait_valid("5a_valid");
        check("5a_data", 32'(fifo.Data_Out), 32'h05A);
        check("5a_err",  32'(fifo.Rx_Error), 32'd0);
        accept();

        cfg_bits = 4'd15; cfg_par = 2'b01; cfg_stop = 1'b1;
        send_frame(9'h0C3, 8, 2'b01, 2, 1'b0, 2'b11);
        wait_valid("clamp_valid");
        check("clamp_data", 32'(fifo.Data_Out), 32'h0C3);
        check("clamp_err",  32'(fifo.Rx_Error), 32'd0);
        accept();

        ovr0 = ovr_cnt;
        for (int k = 0; k < 16; k++) begin
            nb    = int'($urandom_range(5, 9));
            parm  = 2'($urandom_range(0, 3));
            ns    = int'($urandom_range(1, 2));
            d     = 9'($urandom) & mask(nb);
            if ($urandom_range(0, 7) == 0) d = 9'd0;
            flip  = ($urandom_range(0, 5) == 0);
            stops = 2'b11;
            if ($urandom_range(0, 7) == 0) stops[0] = 1'b0;
            if ($urandom_range(0, 7) == 0) stops[1] = 1'b0;
            cfg_bits = 4'(nb);
            cfg_par  = parm;
            cfg_stop = (ns == 2);
            send_frame(d, nb, parm, ns, flip, stops);
            wait_valid($sformatf("rnd%0d_valid", k));
            check($sformatf("rnd%0d_data", k),
                  32'(fifo.Data_Out), 32'(d));
            check($sformatf("rnd%0d_err", k),
                  32'(fifo.Rx_Error),
                  32'(model_err(d, parm, flip, ns, stops)));
            accept();
        end
        check("rnd_novr", 32'(ovr_cnt - ovr0), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
